// File: rtl/booth_mult_ctrl.sv
// booth_mult_ctrl
//   Operand-sequencing front end for a 32-bit radix-2 Booth multiplier core.
//   It accepts one signed operand pair over a valid/ready handshake, loads
//   the core, lets it run STEPS Booth steps, and captures the 64-bit product
//   in the single cycle where it is valid. The product is then held on a
//   valid/ready output until it is consumed.
//
// Optional feature macro: BOOTH_CTRL_ZERO_SKIP_EN
//   When defined, a job with a zero operand bypasses the core. prod_reg is
//   cleared and the FSM goes straight from IDLE to OUT.
//
// Ports
//   clk          clock; all state updates on the rising edge
//   rst          synchronous active-low reset
//   in_valid     operand pair present
//   in_ready     block can accept an operand pair (IDLE only)
//   in_a/in_b    multiplicand / multiplier, two's complement
//   out_valid    out_product holds a finished result
//   out_ready    consumer takes the result
//   out_product  signed 64-bit product
//   busy         high in every state except IDLE
//   mult_load    to core: load operands / park the core
//   mult_a/b     to core: operands, taken from the operand registers
//   mult_product from core: {a,q} register contents
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | ready for an operand pair; core parked (mult_load=1)
// LOAD  | core loads mult_a/mult_b; step counter cleared
// RUN   | core performs one Booth step per cycle, STEPS cycles total
// CAPT  | core product valid this cycle only; captured into prod_reg
// OUT   | product presented until out_ready; core parked
module booth_mult_ctrl #(
  parameter int STEPS = 32,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_product,
  output logic        busy,
  output logic        mult_load,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  input  logic [63:0] mult_product
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_CAPT = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       a_reg, b_reg;
  logic [63:0]       prod_reg;
  logic              zero_op;

`ifdef BOOTH_CTRL_ZERO_SKIP_EN
  assign zero_op = (in_a == 32'd0) || (in_b == 32'd0);
`else
  assign zero_op = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      prod_reg <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_reg <= in_a;
            b_reg <= in_b;
            if (zero_op) prod_reg <= '0;
          end
        end
        S_LOAD:  cnt <= '0;
        S_RUN:   cnt <= cnt + 1'b1;
        // The core keeps shifting after the last step, so this is the only
        // cycle in which mult_product can be taken.
        S_CAPT:  prod_reg <= mult_product;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mult_load = 1'b1;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = zero_op ? S_OUT : S_LOAD;
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        mult_load = 1'b0;
        if (cnt == CNT_LAST) state_d = S_CAPT;
      end
      S_CAPT: begin
        mult_load = 1'b0;
        state_d   = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign mult_a      = a_reg;
  assign mult_b      = b_reg;
  assign out_product = prod_reg;

endmodule
